uc: RTL and testbench

Control unit for the single-cycle, data-memory-less microcontroller datapath. It decodes the 6-bit `Opcode` and the registered zero flag `z` from the datapath and drives `s_inc`, `s_inm`, `we3`, `wez` and `Op`. A small run/halt/error state machine gates the program counter through a new `pc_en` strobe to the datapath PC register. It also keeps a retired-instruction counter for debug.

---
 rtl/uc_pkg.sv | 21 ++
 rtl/uc_dec.sv | 54 +++++
 rtl/uc.sv | 117 +++++++++++
 tb/tb_uc.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the microcontroller control unit.
//   - Opcode constants for the fixed-encoding instructions.
//   - ALU-class mask (opcode MSB set selects the ALU group).
//   - Run/halt/error state encoding.
package uc_pkg;

    // LI occupies 0000xx, so only the upper four opcode bits identify it.
    localparam logic [3:0] OP_LI    = 4'b0000;
    localparam logic [5:0] OP_J     = 6'b000100;
    localparam logic [5:0] OP_JZ    = 6'b000101;
    localparam logic [5:0] OP_JNZ   = 6'b000110;
    localparam logic [5:0] OP_HALT  = 6'b000111;
    localparam logic [5:0] ALU_MASK = 6'b100000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/uc_dec.sv
// uc_dec: purely combinational opcode decoder.
// Ports:
//   Opcode     in  6  instruction opcode field
//   z          in  1  registered zero flag
//   s_inc      out 1  1 = PC+1, 0 = take the jump target
//   s_inm      out 1  immediate path select (LI)
//   we3        out 1  register-file write enable
//   wez        out 1  zero-flag write enable
//   op         out 3  ALU operation
//   is_halt    out 1  opcode is HALT
//   is_illegal out 1  opcode is in the reserved space
module uc_dec
    import uc_pkg::*;
(
    input  logic [5:0] Opcode,
    input  logic       z,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       wez,
    output logic [2:0] op,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        op         = 3'b000;
        is_halt    = 1'b0;
        is_illegal = 1'b0;

        if ((Opcode & ALU_MASK) != 6'b000000) begin
            op  = Opcode[4:2];
            we3 = 1'b1;
            wez = 1'b1;
        end else if (Opcode[5:2] == OP_LI) begin
            s_inm = 1'b1;
            we3   = 1'b1;
        end else begin
            case (Opcode)
                OP_J:    s_inc   = 1'b0;
                OP_JZ:   s_inc   = ~z;
                OP_JNZ:  s_inc   = z;
                OP_HALT: is_halt = 1'b1;
                // 001xxx and 01xxxx
                default: is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc.sv
// uc: control unit for the single-cycle microcontroller datapath.
// Decodes the opcode, gates the PC through pc_en with a run/halt/error
// state machine and counts retired instructions (saturating).
// Ports:
//   clk     in  1    rising-edge clock
//   reset   in  1    asynchronous active-high reset
//   Opcode  in  6    instr[15:10]
//   z       in  1    registered zero flag
//   resume  in  1    leave HALT (only looked at while halted)
//   s_inc, s_inm, we3, wez, Op   datapath control word
//   pc_en   out 1    PC register load enable
//   halted  out 1    machine is in HALT
//   illegal out 1    machine is in ERROR
//   icount  out ICW  retired-instruction count
module uc
    import uc_pkg::*;
#(
    parameter int ICW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [5:0]     Opcode,
    input  logic           z,
    input  logic           resume,
    output logic           s_inc,
    output logic           s_inm,
    output logic           we3,
    output logic           wez,
    output logic [2:0]     Op,
    output logic           pc_en,
    output logic           halted,
    output logic           illegal,
    output logic [ICW-1:0] icount
);

    localparam logic [ICW-1:0] ICNT_ONE = {{(ICW-1){1'b0}}, 1'b1};
    localparam logic [ICW-1:0] ICNT_MAX = {ICW{1'b1}};

    state_t     state, state_nx;
    logic       retire;
    logic       d_s_inc, d_s_inm, d_we3, d_wez, d_halt, d_illegal;
    logic [2:0] d_op;

    uc_dec u_dec (
        .Opcode     (Opcode),
        .z          (z),
        .s_inc      (d_s_inc),
        .s_inm      (d_s_inm),
        .we3        (d_we3),
        .wez        (d_wez),
        .op         (d_op),
        .is_halt    (d_halt),
        .is_illegal (d_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        s_inc    = 1'b1;
        s_inm    = 1'b0;
        we3      = 1'b0;
        wez      = 1'b0;
        Op       = 3'b000;
        pc_en    = 1'b0;
        retire   = 1'b0;

        case (state)
            ST_RUN: begin
                // The decoder already zeroes writes for HALT/illegal, so only
                // the PC strobe needs suppressing here.
                s_inc = d_s_inc;
                s_inm = d_s_inm;
                we3   = d_we3;
                wez   = d_wez;
                Op    = d_op;
                pc_en = 1'b1;
                if (d_halt) begin
                    pc_en    = 1'b0;
                    state_nx = ST_HALT;
                end else if (d_illegal) begin
                    pc_en    = 1'b0;
                    state_nx = ST_ERROR;
                end else begin
                    retire = 1'b1;
                end
            end
            ST_HALT: begin
                // Resume steps the PC past the HALT word; not a retire.
                if (resume) begin
                    pc_en    = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_ERROR: begin
                state_nx = ST_ERROR;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            icount <= '0;
        else if (retire && (icount != ICNT_MAX))
            icount <= icount + ICNT_ONE;
    end

    assign halted  = (state == ST_HALT);
    assign illegal = (state == ST_ERROR);

endmodule

// File: tb/tb_uc.sv
module tb_uc;

    logic       clk;
    logic       reset;
    logic [5:0] Opcode;
    logic       z;
    logic       resume;

    logic        s_inc, s_inm, we3, wez, pc_en, halted, illegal;
    logic [2:0]  Op;
    logic [15:0] icount;

    logic        s_inc4, s_inm4, we3_4, wez4, pc_en4, halted4, illegal4;
    logic [2:0]  Op4;
    logic [3:0]  icount4;

    int checks = 0;
    int errors = 0;

    // behavioural model: 0 = running, 1 = halted, 2 = error
    int ms  = 0;
    int c16 = 0;
    int c4  = 0;

    uc #(.ICW(16)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .resume(resume),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
        .pc_en(pc_en), .halted(halted), .illegal(illegal), .icount(icount)
    );

    uc #(.ICW(4)) dut4 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .resume(resume),
        .s_inc(s_inc4), .s_inm(s_inm4), .we3(we3_4), .wez(wez4), .Op(Op4),
        .pc_en(pc_en4), .halted(halted4), .illegal(illegal4), .icount(icount4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit op_illegal(input logic [5:0] o);
        return !o[5] && (o[4] || o[3]);
    endfunction

    // Model state update from the instruction-set rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ms  = 0;
            c16 = 0;
            c4  = 0;
        end else begin
            case (ms)
                0: begin
                    if (Opcode == 6'b000111)   ms = 1;
                    else if (op_illegal(Opcode)) ms = 2;
                    else begin
                        if (c16 < 65535) c16++;
                        if (c4 < 15)     c4++;
                    end
                end
                1: if (resume) ms = 0;
                default: ms = 2;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic       e_inc, e_inm, e_we3, e_wez, e_pc;
        logic [2:0] e_op;
        e_inc = 1'b1; e_inm = 1'b0; e_we3 = 1'b0; e_wez = 1'b0; e_pc = 1'b0; e_op = 3'd0;
        if (ms == 0) begin
            if (Opcode[5]) begin
                e_op = Opcode[4:2]; e_we3 = 1'b1; e_wez = 1'b1; e_pc = 1'b1;
            end else if (Opcode[5:2] == 4'b0000) begin
                e_inm = 1'b1; e_we3 = 1'b1; e_pc = 1'b1;
            end else if (Opcode == 6'b000100) begin
                e_inc = 1'b0; e_pc = 1'b1;
            end else if (Opcode == 6'b000101) begin
                e_inc = ~z; e_pc = 1'b1;
            end else if (Opcode == 6'b000110) begin
                e_inc = z; e_pc = 1'b1;
            end
        end else if (ms == 1) begin
            e_pc = resume;
        end
        chk("pc_en", pc_en, e_pc);
        if (e_pc) chk("s_inc", s_inc, e_inc);
        chk("s_inm", s_inm, e_inm);
        chk("we3", we3, e_we3);
        chk("wez", wez, e_wez);
        chk("Op", Op, e_op);
        chk("halted", halted, ms == 1);
        chk("illegal", illegal, ms == 2);
        chk("icount", icount, c16);
        chk("icount4", icount4, c4);
        chk("pc_en4", pc_en4, e_pc);
        chk("we3_4", we3_4, e_we3);
        chk("halted4", halted4, ms == 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Opcode = 6'b100100; z = 1'b0; resume = 1'b0;
        #3;
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_icount", icount, 0);
        chk("rst_pc_en", pc_en, 1);
        chk("rst_we3", we3, 1);
        #5 reset = 1'b0;
        #1;
        chk("alu_op", Op, 3'b001);
        chk("alu_wez", wez, 1);
        chk("alu_s_inc", s_inc, 1);
        chk("alu_icount_before", icount, 0);
        step();
        chk("alu_icount_after", icount, 1);
        chk("model_c16_pin", c16, 1);

        Opcode = 6'b000010; #1;
        chk("li_s_inm", s_inm, 1);
        chk("li_we3", we3, 1);
        chk("li_wez", wez, 0);
        step();
        Opcode = 6'b000101; z = 1'b1; #1; chk("jz_z1", s_inc, 0); step();
        z = 1'b0; #1;                     chk("jz_z0", s_inc, 1); step();
        Opcode = 6'b000110; z = 1'b1; #1; chk("jnz_z1", s_inc, 1); step();
        z = 1'b0; #1;                     chk("jnz_z0", s_inc, 0); step();
        chk("icount_after_jumps", icount, 6);

        Opcode = 6'b000111; #1;
        chk("halt_pc_en", pc_en, 0);
        chk("halt_we3", we3, 0);
        step();
        chk("halted_set", halted, 1);
        repeat (5) step();
        chk("halt_icount", icount, 6);
        chk("halt_still", halted, 1);
        resume = 1'b1; #1;
        chk("resume_pc_en", pc_en, 1);
        chk("resume_s_inc", s_inc, 1);
        step();
        resume = 1'b0;
        chk("resume_halted", halted, 0);
        chk("resume_icount", icount, 6);

        Opcode = 6'b010011; #1;
        chk("ill_we3", we3, 0);
        chk("ill_wez", wez, 0);
        chk("ill_pc_en", pc_en, 0);
        step();
        chk("ill_set", illegal, 1);
        resume = 1'b1;
        step(); step();
        chk("ill_resume_ignored", illegal, 1);
        chk("ill_resume_pc_en", pc_en, 0);
        resume = 1'b0;
        #3 reset = 1'b1; Opcode = 6'b100000;
        #1;
        chk("async_illegal", illegal, 0);
        chk("async_icount", icount, 0);
        chk("async_pc_en", pc_en, 1);
        @(posedge clk);
        #4 reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            Opcode = {1'b1, 3'(i % 8), 2'(i % 4)};
            step();
            if (i == 14) chk("sat_reach", icount4, 15);
        end
        chk("sat_hold", icount4, 15);
        chk("wide_count", icount, 20);
        Opcode = 6'b000100; step(); step();
        chk("sat_hold_j", icount4, 15);
        chk("model_c4_pin", c4, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
